// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: word width,
// FSM encoding and the address legality check used by fetch and load paths.
package inst_mem_responder_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // A byte address is usable when word aligned and its word index lies inside the array.
   function automatic logic word_ok(input logic [WORD_W-1:0] a, input int depth);
      logic [WORD_W-1:0] lim;
      logic [WORD_W-1:0] idx;
      lim = depth;
      idx = {2'b00, a[WORD_W-1:2]};
      return (a[1:0] == 2'b00) && (idx < lim);
   endfunction

endpackage

// File: rtl/inst_mem_responder_array.sv
// Instruction storage: one synchronous write port, one synchronous read port,
// write-first on a same-word collision. Only the read register is reset.
module inst_mem_array
   import inst_mem_responder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic              rclr,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // rdata holds between reads, so it doubles as the responder's instruction register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
      end else if (rclr) begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: accepts a fetch, waits WAIT_CYCLES, then returns
// one word (or an error) with a single-cycle valid pulse. Program load is independent.
//
//   state | meaning
//   IDLE  | no fetch outstanding, ready for req
//   WAIT  | fetch accepted, counting down wait states, busy
//   RESP  | valid/instruction/err presented for one cycle, ready for back-to-back req
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH       = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [WORD_W-1:0] addr,
   input  logic              flush,
   input  logic              ld_en,
   input  logic [WORD_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_data,
   output logic              rdy,
   output logic              busy,
   output logic              valid,
   output logic [WORD_W-1:0] instruction,
   output logic              err
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES);

   state_t            state;
   logic [3:0]        cnt;
   logic [WORD_W-1:0] addr_q;

   logic              take_req;
   logic              enter_resp;
   logic [WORD_W-1:0] fetch_addr;
   logic              fetch_ok;
   logic              rd_en;
   logic              rd_clr;
   logic              ld_ok;

   // With zero wait states the accepting edge is also the edge entering RESP,
   // so the read must use the live addr rather than the latched copy.
   always_comb begin
      take_req   = (state != WAIT) && req && !flush;
      fetch_addr = (state == WAIT) ? addr_q : addr;
      fetch_ok   = word_ok(fetch_addr, DEPTH);
      enter_resp = !flush &&
                   (((state == WAIT) && (cnt <= 4'd1)) ||
                    (take_req && (WAIT_CYCLES == 0)));
      rd_en      = enter_resp && fetch_ok;
      rd_clr     = enter_resp && !fetch_ok;
      ld_ok      = ld_en && !rst && word_ok(ld_addr, DEPTH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         addr_q <= '0;
         valid  <= 1'b0;
         err    <= 1'b0;
         rdy    <= 1'b1;
         busy   <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            rdy   <= 1'b1;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE, RESP: begin
                  if (req) begin
                     addr_q <= addr;
                     if (enter_resp) begin
                        state <= RESP;
                        cnt   <= '0;
                        valid <= 1'b1;
                        err   <= !fetch_ok;
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                        rdy   <= 1'b0;
                        busy  <= 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                     rdy   <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
               WAIT: begin
                  if (enter_resp) begin
                     state <= RESP;
                     cnt   <= '0;
                     valid <= 1'b1;
                     err   <= !fetch_ok;
                     rdy   <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  rdy   <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   inst_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (ld_ok),
      .waddr (ld_addr[AW+1:2]),
      .wdata (ld_data),
      .re    (rd_en),
      .rclr  (rd_clr),
      .raddr (fetch_addr[AW+1:2]),
      .rdata (instruction)
   );

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: directed vector table, hand-written reset and
// back-to-back sequences, then random traffic against a transaction-level model.
module tb_inst_mem_responder;

   localparam int W = 2;
   localparam int D = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        flush = 1'b0;
   logic        ld_en = 1'b0;
   logic [31:0] ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        rdy, busy, valid, err;
   logic [31:0] instruction;

   int n_checks = 0;
   int n_fail   = 0;

   inst_mem_responder #(.WAIT_CYCLES(W), .DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .addr        (addr),
      .flush       (flush),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .rdy         (rdy),
      .busy        (busy),
      .valid       (valid),
      .instruction (instruction),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Transaction-level reference: one pending fetch with a due edge number.
   logic [31:0] mem_m [D];
   int          edge_n;
   bit          pend;
   logic [31:0] p_addr;
   int          p_due;
   logic        m_valid, m_err, m_busy, m_rdy;
   logic [31:0] m_instr;

   function automatic void model_reset();
      edge_n  = 0;
      pend    = 1'b0;
      p_addr  = '0;
      p_due   = 0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_busy  = 1'b0;
      m_rdy   = 1'b1;
      m_instr = '0;
   endfunction

   function automatic void model_edge();
      bit was_pend;
      was_pend = pend;
      if (ld_en && ld_addr[1:0] == 2'b00 && ld_addr < 32'(4*D))
         mem_m[ld_addr >> 2] = ld_data;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (flush) begin
         pend = 1'b0;
      end else begin
         if (!was_pend && req) begin
            pend   = 1'b1;
            p_addr = addr;
            p_due  = edge_n + W;
         end
         if (pend && p_due == edge_n) begin
            pend    = 1'b0;
            m_valid = 1'b1;
            if (p_addr[1:0] != 2'b00 || p_addr >= 32'(4*D)) begin
               m_err   = 1'b1;
               m_instr = '0;
            end else begin
               m_instr = mem_m[p_addr >> 2];
            end
         end
      end
      m_busy = pend;
      m_rdy  = !pend;
      edge_n++;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        flush;
      logic        ld_en;
      logic [31:0] ld_addr;
      logic [31:0] ld_data;
      logic        valid, busy, rdy, err;
      logic [31:0] instr;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic rq, input logic [31:0] a, input logic fl,
                      input logic le, input logic [31:0] la, input logic [31:0] ldd,
                      input logic ev, input logic eb, input logic er, input logic ee,
                      input logic [31:0] ei);
      vec_t x;
      x.req = rq; x.addr = a; x.flush = fl;
      x.ld_en = le; x.ld_addr = la; x.ld_data = ldd;
      x.valid = ev; x.busy = eb; x.rdy = er; x.err = ee; x.instr = ei;
      vt.push_back(x);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = int'($urandom % 8);
      if (r == 0) return {24'h0, 6'($urandom % 64), 2'(1 + $urandom % 3)};
      if (r == 1) return 32'h100 + 32'(($urandom % 64) * 4);
      return 32'(($urandom % 64) * 4);
   endfunction

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_state", {valid, busy, rdy, err, instruction}, {1'b0, 1'b0, 1'b1, 1'b0, 32'h0});

      for (int i = 0; i < D; i++) begin
         ld_en = 1'b1; ld_addr = 32'(i * 4); ld_data = $urandom;
         tick();
      end
      ld_en = 1'b0;

      //  req addr     fl  ld addr    data           v  b  r  e  instr
      add(0, 32'h00, 0, 1, 32'h0C, 32'hE3A01005, 0, 0, 1, 0, 32'h0);
      add(1, 32'h0C, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'hE3A01005);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'hE3A01005);
      add(1, 32'h0E, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'hE3A01005);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'hE3A01005);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        1, 0, 1, 1, 32'h0);
      add(1, 32'h100,0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        1, 0, 1, 1, 32'h0);
      add(0, 32'h00, 0, 1, 32'h10, 32'h11112222, 0, 0, 1, 0, 32'h0);
      add(1, 32'h10, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0);
      add(0, 32'h00, 1, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h0);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h0);
      add(1, 32'h10, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h11112222);
      add(0, 32'h00, 0, 1, 32'h14, 32'hAAAA0001, 0, 0, 1, 0, 32'h11112222);
      add(1, 32'h14, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h11112222);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h11112222);
      add(0, 32'h00, 0, 1, 32'h14, 32'h5555BEEF, 1, 0, 1, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h5555BEEF);
      add(1, 32'h14, 1, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 1, 32'h00, 32'h0BADF00D, 0, 0, 1, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 1, 32'h15, 32'hDEADDEAD, 0, 0, 1, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 1, 32'h100,32'hDEADDEAD, 0, 0, 1, 0, 32'h5555BEEF);
      add(1, 32'h14, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h5555BEEF);
      add(1, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h5555BEEF);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h0BADF00D);
      add(1, 32'h0C, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0BADF00D);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 1, 0, 0, 32'h0BADF00D);
      add(0, 32'h00, 1, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h0BADF00D);
      add(0, 32'h00, 0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h0BADF00D);

      foreach (vt[i]) begin
         req = vt[i].req; addr = vt[i].addr; flush = vt[i].flush;
         ld_en = vt[i].ld_en; ld_addr = vt[i].ld_addr; ld_data = vt[i].ld_data;
         tick();
         chk($sformatf("vec%0d", i), {valid, busy, rdy, err, instruction},
             {vt[i].valid, vt[i].busy, vt[i].rdy, vt[i].err, vt[i].instr});
      end
      req = 1'b0; flush = 1'b0; ld_en = 1'b0;

      // Continuous request: responses every W+1 cycles, never idle in between.
      req = 1'b1; addr = 32'h0C;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk($sformatf("b2b%0d", k), {valid, busy, rdy, err},
             {(k % 3 == 2), (k % 3 != 2), (k % 3 == 2), 1'b0});
         if (k % 3 == 2) chk($sformatf("b2b_instr%0d", k), instruction, 32'hE3A01005);
      end
      req = 1'b0;
      tick();
      chk("b2b_idle", {valid, busy, rdy}, {1'b0, 1'b0, 1'b1});

      // Reset in the middle of WAIT, with a load attempted while in reset.
      req = 1'b1; addr = 32'h0C;
      tick();
      req = 1'b0;
      tick();
      chk("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("async_rst", {valid, busy, rdy, err, instruction}, {1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
      model_reset();
      ld_en = 1'b1; ld_addr = 32'h0C; ld_data = 32'hFFFFFFFF;
      tick();
      ld_en = 1'b0;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("post_rst%0d", k), {valid, busy, rdy}, {1'b0, 1'b0, 1'b1});
      end
      req = 1'b1; addr = 32'h0C;
      tick();
      req = 1'b0;
      tick();
      tick();
      chk("post_rst_fetch", {valid, err, instruction}, {1'b1, 1'b0, 32'hE3A01005});

      for (int i = 0; i < 500; i++) begin
         req     = 1'($urandom % 2);
         addr    = rand_addr();
         flush   = ($urandom % 12 == 0);
         ld_en   = ($urandom % 4 == 0);
         ld_addr = rand_addr();
         ld_data = $urandom;
         tick();
         chk($sformatf("rand%0d", i), {valid, busy, rdy, err, instruction},
             {m_valid, m_busy, m_rdy, m_err, m_instr});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and response, range 0..15.
REQ-002 Parameter DEPTH, default 64: number of 32-bit instruction words held.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  fetch request from the fetch stage, sampled when rdy=1.
REQ-006 addr  input  32  byte address of requested instruction (PC).
REQ-007 flush  input  1  abort any outstanding fetch (branch taken).
REQ-008 ld_en  input  1  program-load write strobe.
REQ-009 ld_addr  input  32  byte address of load write.
REQ-010 ld_data  input  32  load write data.
REQ-011 rdy  output  1  responder can accept req this cycle.
REQ-012 busy  output  1  fetch outstanding; drives fetch-stage freeze.
REQ-013 valid  output  1  one-cycle pulse: instruction/err valid.
REQ-014 instruction  output  32  fetched word.
REQ-015 err  output  1  qualifies valid: misaligned or out-of-range address.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP.
REQ-017 IDLE: rdy=1, busy=0; on req=1 latch addr, load wait counter with WAIT_CYCLES, go WAIT (or RESP directly if WAIT_CYCLES=0).
REQ-018 WAIT: rdy=0, busy=1; counter decrements each cycle; on counter reaching 1 (or 0 when loaded 0) the next state SHALL be RESP.
REQ-019 Total latency SHALL be exactly WAIT_CYCLES+1 cycles from the accepting edge to the edge at which valid rises.
REQ-020 RESP: valid=1 and busy=0 for exactly one cycle; instruction/err registered on entry to RESP.
REQ-021 RESP: rdy=1; a req in RESP SHALL be accepted (back-to-back), otherwise return to IDLE.
REQ-022 Memory read SHALL occur on the edge entering RESP using the latched address; word index = addr[31:2].
REQ-023 addr[1:0]!=0 or word index >= DEPTH SHALL produce err=1 with instruction=0; no memory access.
REQ-024 instruction SHALL hold its last value outside RESP; err SHALL be 0 outside RESP.
REQ-025 flush=1 in any state SHALL force IDLE next edge, suppress valid, and ignore a simultaneous req.
REQ-026 ld_en writes ld_data to word ld_addr[31:2] synchronously; misaligned/out-of-range load writes SHALL be dropped silently.
REQ-027 Load write and read of the same word on the same edge SHALL return the new data (write-first).
REQ-028 Load writes SHALL be accepted in every state, independent of the FSM.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, counter=0, valid=0, err=0, busy=0, instruction=0, rdy=1 after release.
REQ-030 Memory contents SHALL NOT be reset; rst mid-fetch SHALL discard the fetch with no valid pulse.
REQ-031 Loads with rst=1 SHALL be ignored.

Structure
REQ-032 FSM state encoding and the 32-bit word width constant SHALL live in the shared ARM package.
REQ-033 The storage array SHALL be a sub-module inst_mem_array (one sync write port, one sync read port, write-first).
REQ-034 Implementation SHALL be one clocked process for FSM/counter/outputs plus the array instance.

Verification (WAIT_CYCLES=2, DEPTH=64)
REQ-035 Load word 3 = 0xE3A01005; req with addr=0x0C at cycle 0 -> busy high cycles 1-2, valid=1 with instruction=0xE3A01005, err=0 at cycle 3.
REQ-036 req addr=0x0C held continuously -> valid pulses every 3 cycles, rdy=1 only in IDLE/RESP.
REQ-037 req addr=0x0E -> valid=1, err=1, instruction=0 after 3 cycles; req addr=0x100 -> same err response.
REQ-038 flush at cycle 2 of a fetch -> no valid pulse, rdy=1 next cycle, next req served normally.
REQ-039 ld_en to word 5 on the edge entering RESP for addr=0x14 -> instruction equals the newly written ld_data.
REQ-040 rst asserted mid-WAIT -> outputs reset immediately, no valid; memory still returns previously loaded data afterwards.
